// File: rtl/sp_pkg.sv
// ============================================================================
// Module : sp_pkg
// Brief  : Shared state encoding and default width for the serial payload
//          collector.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package sp_pkg;

  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_HOLD   = 2'd3
  } sp_state_t;

endpackage : sp_pkg

`default_nettype wire

// File: rtl/payload_shreg.sv
// ============================================================================
// Module : payload_shreg
// Brief  : MSB-first shift register with bit counter and frame-position flags.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module payload_shreg
  import sp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic              i_shift,
  input  logic              i_bit,
  output logic [DATA_W-1:0] o_word,
  output logic [DATA_W-1:0] o_next_word,
  output logic              o_last,
  output logic              o_full
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] r_shreg;
  logic [CNT_W-1:0]  r_count;

  // Load starts a fresh frame with the incoming bit so the first bit is kept.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_shreg <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_shreg <= {{(DATA_W-1){1'b0}}, i_bit};
      r_count <= CNT_W'(1);
    end else if (i_shift) begin
      r_shreg <= o_next_word;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_word      = r_shreg;
  assign o_next_word = {r_shreg[DATA_W-2:0], i_bit};
  assign o_last      = (r_count == CNT_W'(DATA_W - 1));
  assign o_full      = (r_count == CNT_W'(DATA_W));

endmodule : payload_shreg

`default_nettype wire

// File: rtl/serial_payload_collector.sv
// ============================================================================
// Module : serial_payload_collector
// Brief  : Deserialises DATA_W payload bits (MSB first) into a word offered on
//          a valid/ready handshake. Define PAYLOAD_PARITY_EN for a trailing
//          even-parity bit per frame.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_payload_collector
  import sp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Active,
  input  logic              BitIn,
  input  logic              BitValid,
  output logic [DATA_W-1:0] DataOut,
  output logic              DataValid,
  input  logic              DataReady,
  output logic              Busy,
  output logic              Overrun,
  output logic              ParityErr
);

  sp_state_t         r_state;
  sp_state_t         w_state_nxt;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nxt;
  logic              r_valid;
  logic              w_valid_nxt;
  logic              r_ovr;
  logic              w_ovr_nxt;
  logic              r_perr;
  logic              w_perr_nxt;

  logic              w_clear;
  logic              w_load;
  logic              w_shift;
  logic [DATA_W-1:0] w_word;
  logic [DATA_W-1:0] w_next_word;
  logic              w_last;
  logic              w_full;

  payload_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk         (Clk),
    .rst         (Reset),
    .i_clear     (w_clear),
    .i_load      (w_load),
    .i_shift     (w_shift),
    .i_bit       (BitIn),
    .o_word      (w_word),
    .o_next_word (w_next_word),
    .o_last      (w_last),
    .o_full      (w_full)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ovr   <= w_ovr_nxt;
      r_perr  <= w_perr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_valid_nxt = r_valid;
    w_ovr_nxt   = 1'b0;
    w_perr_nxt  = 1'b0;
    w_clear     = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (Active && BitValid) begin
          w_load      = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (!Active) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (BitValid) begin
          if (w_last) begin
`ifdef PAYLOAD_PARITY_EN
            w_shift     = 1'b1;
            w_state_nxt = ST_PARITY;
`else
            w_clear     = 1'b1;
            w_data_nxt  = w_next_word;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
`endif
          end else begin
            w_shift = 1'b1;
          end
        end
      end
      ST_PARITY: begin
`ifdef PAYLOAD_PARITY_EN
        if (!Active || !w_full) begin
          w_clear     = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (BitValid) begin
          w_clear = 1'b1;
          if (^{w_word, BitIn} == 1'b0) begin
            w_data_nxt  = w_word;
            w_valid_nxt = 1'b1;
            w_state_nxt = ST_HOLD;
          end else begin
            w_perr_nxt  = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
`else
        w_clear     = 1'b1;
        w_state_nxt = ST_IDLE;
`endif
      end
      ST_HOLD: begin
        // Bits arriving while a word is pending are dropped, even on the accept cycle.
        w_ovr_nxt = BitValid;
        if (DataReady) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_clear     = 1'b1;
        w_valid_nxt = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

`ifndef PAYLOAD_PARITY_EN
  logic w_unused_flags;
  assign w_unused_flags = w_full ^ (^w_word);
`endif

  assign DataOut   = r_data;
  assign DataValid = r_valid;
  assign Busy      = (r_state == ST_SHIFT) || (r_state == ST_PARITY);
  assign Overrun   = r_ovr;
`ifdef PAYLOAD_PARITY_EN
  assign ParityErr = r_perr;
`else
  assign ParityErr = 1'b0;
`endif

endmodule : serial_payload_collector

`default_nettype wire

// File: tb/tb_serial_payload_collector.sv
// ============================================================================
// Module : tb_serial_payload_collector
// Brief  : Directed, self-checking bench with a queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_payload_collector;

  localparam int DATA_W = 8;
`ifdef PAYLOAD_PARITY_EN
  localparam int FRAME_LEN = DATA_W + 1;
`else
  localparam int FRAME_LEN = DATA_W;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              Active = 1'b0;
  logic              BitIn = 1'b0;
  logic              BitValid = 1'b0;
  logic              DataReady = 1'b0;
  logic [DATA_W-1:0] DataOut;
  logic              DataValid;
  logic              Busy;
  logic              Overrun;
  logic              ParityErr;

  int checks = 0;
  int failures = 0;

  serial_payload_collector #(.DATA_W(DATA_W)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Active    (Active),
    .BitIn     (BitIn),
    .BitValid  (BitValid),
    .DataOut   (DataOut),
    .DataValid (DataValid),
    .DataReady (DataReady),
    .Busy      (Busy),
    .Overrun   (Overrun),
    .ParityErr (ParityErr)
  );

  always #5 Clk = ~Clk;

  // Reference model: a frame is a queue of bits; a word is pending until accepted.
  bit                m_bits[$];
  logic [DATA_W-1:0] e_data = '0;
  logic              e_valid = 1'b0;
  logic              e_busy = 1'b0;
  logic              e_ovr = 1'b0;
  logic              e_perr = 1'b0;

  always @(posedge Clk) begin
    int unsigned word;
    int          par;
    e_ovr  = 1'b0;
    e_perr = 1'b0;
    if (Reset) begin
      m_bits.delete();
      e_data  = '0;
      e_valid = 1'b0;
    end else if (e_valid) begin
      if (BitValid) e_ovr = 1'b1;
      if (DataReady) e_valid = 1'b0;
    end else if (!Active) begin
      m_bits.delete();
    end else if (BitValid) begin
      m_bits.push_back(BitIn);
      if (m_bits.size() == FRAME_LEN) begin
        word = 0;
        par  = 0;
        for (int i = 0; i < FRAME_LEN; i++) begin
          if (i < DATA_W) word = word * 2 + int'(m_bits[i]);
          par = par + int'(m_bits[i]);
        end
        if (par % 2 == 0 || FRAME_LEN == DATA_W) begin
          e_data  = DATA_W'(word);
          e_valid = 1'b1;
        end else begin
          e_perr = 1'b1;
        end
        m_bits.delete();
      end
    end
    e_busy = (m_bits.size() != 0);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    check("model_DataValid", 32'(DataValid), 32'(e_valid));
    check("model_DataOut",   32'(DataOut),   32'(e_data));
    check("model_Busy",      32'(Busy),      32'(e_busy));
    check("model_Overrun",   32'(Overrun),   32'(e_ovr));
    check("model_ParityErr", 32'(ParityErr), 32'(e_perr));
  end

  task automatic send_bit(input logic b);
    BitIn    = b;
    BitValid = 1'b1;
    @(negedge Clk);
    BitValid = 1'b0;
    BitIn    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge Clk);
  endtask

  task automatic send_word(input logic [DATA_W-1:0] w);
    for (int i = DATA_W - 1; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] w);
    send_word(w);
`ifdef PAYLOAD_PARITY_EN
    send_bit(^w);
`endif
  endtask

  initial begin
    logic [DATA_W-1:0] w;
    idle(2);
    check("reset_DataValid", 32'(DataValid), 32'd0);
    check("reset_DataOut",   32'(DataOut),   32'd0);
    check("reset_Busy",      32'(Busy),      32'd0);
    Reset = 1'b0;
    idle(1);

    // 1: basic frame, consumer always ready
    Active = 1'b1; DataReady = 1'b1;
    send_frame(8'hB2);
    check("t1_valid", 32'(DataValid), 32'd1);
    check("t1_data",  32'(DataOut),   32'hB2);
    idle(1);
    check("t1_accepted", 32'(DataValid), 32'd0);
    check("t1_dataheld", 32'(DataOut),   32'hB2);

    // 2: stalled consumer, overruns, then recovery
    DataReady = 1'b0;
    send_frame(8'h5A);
    for (int i = 0; i < 3; i++) begin
      send_bit(1'b1);
      check("t2_overrun", 32'(Overrun), 32'd1);
    end
    check("t2_held", 32'(DataOut), 32'h5A);
    Active = 1'b0;
    idle(2);
    check("t2_hold_inactive", 32'(DataValid), 32'd1);
    Active = 1'b1;
    // accept and a stray bit in the same cycle: bit dropped as overrun
    DataReady = 1'b1;
    send_bit(1'b1);
    check("t2_accept_ovr", 32'(Overrun), 32'd1);
    check("t2_no_frame",   32'(Busy),    32'd0);
    send_frame(8'h3C);
    check("t2_next", 32'(DataOut), 32'h3C);
    idle(1);

    // 3: abort by Active dropping mid-frame
    w = 8'hFF;
    for (int i = 0; i < 4; i++) send_bit(w[7-i]);
    check("t3_busy", 32'(Busy), 32'd1);
    Active = 1'b0;
    idle(2);
    check("t3_abort_busy",  32'(Busy),      32'd0);
    check("t3_abort_valid", 32'(DataValid), 32'd0);
    Active = 1'b1;
    send_frame(8'h0F);
    check("t3_data", 32'(DataOut), 32'h0F);
    idle(1);

    // 4: reset mid-frame
    w = 8'h81;
    for (int i = 0; i < 5; i++) send_bit(w[7-i]);
    Reset = 1'b1;
    idle(1);
    Reset = 1'b0;
    check("t4_busy", 32'(Busy),    32'd0);
    check("t4_data", 32'(DataOut), 32'd0);
    send_frame(8'h81);
    check("t4_frame", 32'(DataOut), 32'h81);
    idle(1);

`ifdef PAYLOAD_PARITY_EN
    // 5: parity good and bad
    send_word(8'hB2);
    send_bit(1'b0);
    check("t5_good_valid", 32'(DataValid), 32'd1);
    check("t5_good_data",  32'(DataOut),   32'hB2);
    idle(1);
    send_word(8'hB2);
    send_bit(1'b1);
    check("t5_bad_perr",  32'(ParityErr), 32'd1);
    check("t5_bad_valid", 32'(DataValid), 32'd0);
    idle(1);
`endif

    // 6: gaps between bits
    w = 8'hC3;
    for (int i = 0; i < DATA_W; i++) begin
      send_bit(w[7-i]);
      if (i < DATA_W - 1) begin
        for (int g = 0; g < (i % 6); g++) begin
          check("t6_busy_gap", 32'(Busy), 32'd1);
          @(negedge Clk);
        end
      end
    end
`ifdef PAYLOAD_PARITY_EN
    send_bit(^w);
`endif
    check("t6_data",  32'(DataOut),   32'hC3);
    check("t6_valid", 32'(DataValid), 32'd1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_payload_collector

`default_nettype wire
